// File: rtl/twos_to_sign_bcd.sv
// Signed two's-complement to sign/magnitude/BCD converter, one double-dabble step per clock.
// Optional leading-zero blank mask enabled by defining TWOS_TO_SIGN_BCD_BLANK_EN.
module twos_to_sign_bcd #(
   parameter int W      = 7,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [W-1:0]          in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  sign,
   output logic [W-1:0]          mag,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [DIGITS-1:0]     blank
);

   localparam int SW = 4*DIGITS + W;
   localparam int CW = $clog2(W+1);

   typedef enum logic [1:0] {
      IDLE,
      CONVERT,
      DONE
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [SW-1:0]  sr;
   logic [SW-1:0]  sr_adj;
   logic [SW-1:0]  sr_nxt;
   logic [CW-1:0]  cnt;
   logic [W-1:0]   mag_in;
   logic           accept;
   logic           last;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid & in_ready;
   assign last      = (state == CONVERT) && (cnt == CW'(1));

   // read as unsigned, so the most negative operand maps to 2^(W-1)
   assign mag_in = in_data[W-1] ? (~in_data + W'(1)) : in_data;

   always_comb begin
      sr_adj = sr;
      for (int i = 0; i < DIGITS; i++) begin
         if (sr[W+4*i +: 4] >= 4'd5)
            sr_adj[W+4*i +: 4] = sr[W+4*i +: 4] + 4'd3;
      end
      sr_nxt = sr_adj << 1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (in_valid) state_nxt = CONVERT;
         CONVERT: if (last)     state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sr   <= '0;
         cnt  <= '0;
         sign <= 1'b0;
         mag  <= '0;
         bcd  <= '0;
      end else if (accept) begin
         sign <= in_data[W-1];
         mag  <= mag_in;
         sr   <= {{(4*DIGITS){1'b0}}, mag_in};
         cnt  <= CW'(W);
      end else if (state == CONVERT) begin
         sr  <= sr_nxt;
         cnt <= cnt - CW'(1);
         if (last)
            bcd <= sr_nxt[SW-1:W];
      end
   end

`ifdef TWOS_TO_SIGN_BCD_BLANK_EN
   logic [DIGITS-1:0] blank_nxt;
   logic              hi_zero;

   // a digit blanks only while every digit above it is zero too
   always_comb begin
      blank_nxt = '0;
      hi_zero   = 1'b1;
      for (int i = DIGITS-1; i > 0; i--) begin
         hi_zero      = hi_zero & (sr_nxt[W+4*i +: 4] == 4'd0);
         blank_nxt[i] = hi_zero;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         blank <= '0;
      else if (last)
         blank <= blank_nxt;
   end
`else
   assign blank = '0;
`endif

endmodule

// File: tb/tb_twos_to_sign_bcd.sv
// Directed plus random bench for twos_to_sign_bcd against a decimal reference model.
module tb_twos_to_sign_bcd;

   localparam int W = 7;
   localparam int D = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   in_data;
   logic           out_valid;
   logic           out_ready;
   logic           sign;
   logic [W-1:0]   mag;
   logic [4*D-1:0] bcd;
   logic [D-1:0]   blank;

   int checks = 0;
   int errors = 0;

   twos_to_sign_bcd #(.W(W), .DIGITS(D)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .sign(sign), .mag(mag), .bcd(bcd), .blank(blank)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int ref_mag(input logic [W-1:0] v);
      int s;
      s = v[W-1] ? int'(v) - (1 << W) : int'(v);
      return (s < 0) ? -s : s;
   endfunction

   function automatic logic [4*D-1:0] ref_bcd(input int m);
      logic [4*D-1:0] r;
      int x;
      r = '0;
      x = m;
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [D-1:0] ref_blank(input int m);
      logic [D-1:0] r;
      r = '0;
`ifdef TWOS_TO_SIGN_BCD_BLANK_EN
      for (int i = 1; i < D; i++)
         if (m < 10 ** i) r[i] = 1'b1;
`endif
      return r;
   endfunction

   task automatic accept_op(input logic [W-1:0] v);
      int n;
      n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = v;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // accept, then follow in_ready low through CONVERT and DONE
   task automatic run(input string tag, input logic [W-1:0] v);
      int lowc, lat, m;
      logic got;
      logic s_o;
      logic [W-1:0] m_o;
      logic [4*D-1:0] b_o;
      logic [D-1:0] k_o;
      accept_op(v);
      lowc = 0; lat = -1; got = 1'b0;
      s_o = 1'b0; m_o = '0; b_o = '0; k_o = '0;
      while (!in_ready && lowc < 100) begin
         if (out_valid && !got) begin
            got = 1'b1; lat = lowc;
            s_o = sign; m_o = mag; b_o = bcd; k_o = blank;
         end
         lowc++;
         @(posedge clk); #1;
      end
      m = ref_mag(v);
      chk({tag, "_lat"}, lat, W);
      chk({tag, "_sign"}, s_o, v[W-1]);
      chk({tag, "_mag"}, m_o, m);
      chk({tag, "_bcd"}, b_o, ref_bcd(m));
      chk({tag, "_blank"}, k_o, ref_blank(m));
      chk({tag, "_busy"}, lowc, W + 1);
   endtask

   initial begin
      logic [W-1:0] v;
      int n;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_ready", in_ready, 1);
      chk("rst_valid", out_valid, 0);
      chk("rst_sign", sign, 0);
      chk("rst_mag", mag, 0);
      chk("rst_bcd", bcd, 0);
      chk("rst_blank", blank, 0);

      run("m64", 7'b1000000);
      run("p63", 7'd63);
      run("m1", 7'b1111111);
      run("zero", 7'd0);

      // backpressure on a result of 42
      out_ready = 1'b0;
      accept_op(7'd42);
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bp_lat", n, W);
      for (int i = 0; i < 20; i++) begin
         if (i == 5) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 7'd5;
         end
         if (i == 6) in_valid = 1'b0;
         @(posedge clk); #1;
         chk("bp_valid", out_valid, 1);
         chk("bp_bcd", bcd, 12'h042);
         chk("bp_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      chk("bp_mag", mag, 42);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_rel_valid", out_valid, 0);
      chk("bp_rel_ready", in_ready, 1);

      // reset during the third CONVERT cycle of -37
      accept_op(7'(-37));
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_valid", out_valid, 0);
      chk("mid_ready", in_ready, 1);
      chk("mid_sign", sign, 0);
      chk("mid_mag", mag, 0);
      chk("mid_bcd", bcd, 0);
      chk("mid_blank", blank, 0);
      run("p25", 7'd25);

      // rst together with in_valid drops the operand
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b1; in_data = 7'd9;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_in_mag", mag, 0);

      for (int i = 0; i < 30; i++) begin
         v = W'($urandom_range(0, (1 << W) - 1));
         run("rnd", v);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
